fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one 8-deep synchronous FIFO's write side (wn/DATAIN/full) between NREQ packet producers. Each producer uses a valid/ready handshake; once a producer wins, it keeps the port until its last beat, so packets are never interleaved. A run limiter inserts periodic idle write cycles. This is needed because the FIFO gives writes priority over reads, and continuous writes would starve the reader.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 35 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// The read-side scheduler imports this as well.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF    = 4;
  localparam int DW_DEF      = 8;
  localparam int MAX_RUN_DEF = 4;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle for the arbiter.
// slave: the arbiter; master: producers plus the FIFO flag.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int GW   = gid_w(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wn;
  logic [DW-1:0]      fifo_din;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport slave (
    input  req_valid, req_data, req_last,
    input  fifo_full,
    output req_ready, fifo_wn, fifo_din,
    output grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last,
    output fifo_full,
    input  req_ready, fifo_wn, fifo_din,
    input  grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit after
// last, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = NREQ_DEF,
  parameter int W = gid_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int j;
    logic [W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      jj = W'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked write arbiter for a shared FIFO,
// with a run limiter that leaves idle cycles for the reader.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int GW = gid_w(NREQ);
  localparam int RW =
    (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;
  localparam logic [RW-1:0] RMAX = RW'(MAX_RUN);

  localparam logic [0:0] S_IDLE   = 1'(ST_IDLE);
  localparam logic [0:0] S_LOCKED = 1'(ST_LOCKED);

  logic [0:0]    state;
  logic [GW-1:0] owner;
  logic [GW-1:0] last_owner;
  logic [RW-1:0] run_cnt;

  logic          found;
  logic [GW-1:0] pidx;
  logic [GW-1:0] gnt;
  logic [DW-1:0] gdata;
  logic          gvalid;
  logic          glast;
  logic          bubble;
  logic          can_wr;

  rr_pick #(
    .N (NREQ),
    .W (GW)
  ) u_pick (
    .req   (bus.req_valid),
    .last  (last_owner),
    .found (found),
    .idx   (pidx)
  );

  always_comb begin
    gnt    = (state == S_LOCKED) ? owner : pidx;
    gvalid = bus.req_valid[gnt]
           & ((state == S_LOCKED) | found);
    glast  = bus.req_last[gnt];
    gdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == GW'(i)) gdata = bus.req_data[i*DW +: DW];
    end
    bubble = (MAX_RUN > 0) && (run_cnt == RMAX);
    can_wr = gvalid & ~bus.fifo_full & ~bubble & ~reset;
  end

  always_comb begin
    bus.req_ready = '0;
    if (can_wr) bus.req_ready[gnt] = 1'b1;
    bus.fifo_wn  = can_wr;
    bus.fifo_din = can_wr ? gdata : '0;
    bus.grant_id = reset ? '0 : gnt;
    bus.busy     = ~reset & (state == S_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= GW'(NREQ - 1);
      run_cnt    <= '0;
    end else begin
      if (MAX_RUN > 0)
        run_cnt <= can_wr ? run_cnt + RW'(1) : '0;
      case (state)
        S_IDLE: begin
          // A blocked winner still locks so the grant cannot migrate.
          if (found) begin
            if (can_wr && glast) begin
              last_owner <= pidx;
            end else begin
              state <= S_LOCKED;
              owner <= pidx;
            end
          end
        end
        S_LOCKED: begin
          if (can_wr && glast) begin
            state      <= S_IDLE;
            last_owner <= owner;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets,
// expected writes queued at stimulus time, checked by a monitor.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = gid_w(N);

  typedef struct packed {
    logic [GW-1:0] id;
    logic [DW-1:0] d;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_wr_arbiter_if #(.NREQ(N), .DW(DW), .GW(GW)) bus();

  fifo_wr_arbiter #(
    .NREQ    (N),
    .DW      (DW),
    .MAX_RUN (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t         sb [$];
  logic [DW:0]  rq [N][$];
  logic [N-1:0] en    = '0;
  logic [N-1:0] rdy_s = '0;
  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic [DW:0] b;
    for (int i = 0; i < N; i++) begin
      if (en[i] && rq[i].size() > 0) begin
        b = rq[i][0];
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*DW +: DW] = b[DW-1:0];
        bus.req_last[i]           = b[DW];
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
        bus.req_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++)
      if (rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
  endtask

  task automatic idle(int n);
    repeat (n) begin apply(); tick(); end
  endtask

  task automatic send(int id, logic [DW-1:0] d, logic l);
    rq[id].push_back({l, d});
  endtask

  task automatic expw(int id, logic [DW-1:0] d);
    exp_t e;
    e.id = GW'(id);
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic drain(string name, int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      apply();
      tick();
      k++;
    end
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    rdy_s = bus.req_ready;
    if (bus.fifo_wn === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: id %0d data %0h",
                 bus.grant_id, bus.fifo_din);
      end else begin
        e = sb.pop_front();
        chk("wr_id", bus.grant_id, e.id);
        chk("wr_data", bus.fifo_din, e.d);
        chk("wr_ready", bus.req_ready, 1 << e.id);
      end
    end
  end

  initial begin
    logic [11:0] pat;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;

    // reset: outputs forced quiet even with a valid requester
    reset = 1'b1;
    en    = 4'b0010;
    send(1, 8'h77, 1'b1);
    apply();
    chk("rst_wn", bus.fifo_wn, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_din", bus.fifo_din, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    tick();
    tick();
    reset = 1'b0;
    en    = '0;
    rq[1].delete();
    apply();
    chk("idle_wn", bus.fifo_wn, 0);
    chk("idle_busy", bus.busy, 0);
    tick();

    // single-beat packets from 0 and 2
    send(0, 8'hA0, 1'b1);
    send(2, 8'hA2, 1'b1);
    expw(0, 8'hA0);
    expw(2, 8'hA2);
    en = 4'b0101;
    apply();
    chk("t1_grant0", bus.grant_id, 0);
    chk("t1_din0", bus.fifo_din, 8'hA0);
    tick();
    apply();
    chk("t1_grant2", bus.grant_id, 2);
    chk("t1_din2", bus.fifo_din, 8'hA2);
    chk("t1_busy", bus.busy, 0);
    tick();
    idle(2);

    // 3-beat packet from 1, requester 3 arrives mid-packet
    en = 4'b0010;
    send(1, 8'h11, 1'b0);
    send(1, 8'h12, 1'b0);
    send(1, 8'h13, 1'b1);
    send(3, 8'h3F, 1'b1);
    expw(1, 8'h11);
    expw(1, 8'h12);
    expw(1, 8'h13);
    expw(3, 8'h3F);
    apply();
    chk("t2_c1_wn", bus.fifo_wn, 1);
    chk("t2_c1_din", bus.fifo_din, 8'h11);
    tick();
    en[3] = 1'b1;
    apply();
    chk("t2_c2_grant", bus.grant_id, 1);
    chk("t2_c2_din", bus.fifo_din, 8'h12);
    chk("t2_c2_busy", bus.busy, 1);
    tick();
    apply();
    chk("t2_c3_din", bus.fifo_din, 8'h13);
    chk("t2_c3_busy", bus.busy, 1);
    tick();
    apply();
    chk("t2_c4_grant", bus.grant_id, 3);
    chk("t2_c4_wn", bus.fifo_wn, 1);
    tick();
    idle(2);

    // 10-beat stream: bubble after every 4 writes
    en = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      send(0, 8'hC0 + 8'(k), (k == 9));
      expw(0, 8'hC0 + 8'(k));
    end
    pat = 12'b1111_0_1111_0_11;
    for (int k = 0; k < 12; k++) begin
      apply();
      chk($sformatf("t3_wn%0d", k), bus.fifo_wn, pat[11-k]);
      tick();
    end
    chk("t3_q_empty", rq[0].size(), 0);
    idle(2);

    // full for 3 cycles mid-packet
    en = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      send(1, 8'h40 + 8'(k), (k == 5));
      expw(1, 8'h40 + 8'(k));
    end
    send(3, 8'h3E, 1'b1);
    expw(3, 8'h3E);
    apply();
    chk("t4_c1_grant", bus.grant_id, 1);
    tick();
    apply();
    chk("t4_c2_wn", bus.fifo_wn, 1);
    tick();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply();
      chk("t4_full_wn", bus.fifo_wn, 0);
      chk("t4_full_ready", bus.req_ready, 0);
      chk("t4_full_grant", bus.grant_id, 1);
      chk("t4_full_busy", bus.busy, 1);
      tick();
    end
    bus.fifo_full = 1'b0;
    apply();
    chk("t4_resume_wn", bus.fifo_wn, 1);
    chk("t4_resume_din", bus.fifo_din, 8'h42);
    tick();
    drain("t4_drain", 20);
    idle(2);

    // reset mid-packet from 2 while 0 waits
    en = 4'b0100;
    send(2, 8'h21, 1'b0);
    send(2, 8'h22, 1'b0);
    send(2, 8'h23, 1'b0);
    send(2, 8'h24, 1'b1);
    send(0, 8'h05, 1'b1);
    expw(2, 8'h21);
    expw(0, 8'h05);
    expw(2, 8'h22);
    expw(2, 8'h23);
    expw(2, 8'h24);
    apply();
    chk("t5_c1_grant", bus.grant_id, 2);
    chk("t5_c1_din", bus.fifo_din, 8'h21);
    tick();
    en[0] = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      apply();
      chk("t5_rst_wn", bus.fifo_wn, 0);
      chk("t5_rst_ready", bus.req_ready, 0);
      chk("t5_rst_din", bus.fifo_din, 0);
      chk("t5_rst_busy", bus.busy, 0);
      tick();
    end
    reset = 1'b0;
    apply();
    chk("t5_post_grant", bus.grant_id, 0);
    chk("t5_post_din", bus.fifo_din, 8'h05);
    tick();
    drain("t5_drain", 20);
    idle(2);

    // all requesters valid: strict 0,1,2,3 rotation
    reset = 1'b1;
    apply();
    tick();
    reset = 1'b0;
    en = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        send(i, 8'h80 | 8'(i << 4) | 8'(r), 1'b1);
        expw(i, 8'h80 | 8'(i << 4) | 8'(r));
      end
    end
    drain("t6_drain", 30);
    idle(2);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
